// File: rtl/ram_8bits_pkg.sv
// Shared parameters, word type and test-image generator for ram_8bits.
package ram_8bits_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 8;

  typedef logic [WIDTH-1:0] word_t;

  // Preload pattern: word index in the upper five bits, fixed 3'b101 tag below.
  function automatic word_t test_image(input logic [4:0] i);
    return {i, 3'b101};
  endfunction

endpackage

// File: rtl/ram_8bits.sv
// ram_8bits: 32 x 8 synchronous RAM with registered read-first output and a
// single-edge test-image preload.
// Ports:
//   clk          - clock, all state changes on rising edge
//   rst_n        - asynchronous active-low reset (clears array and output)
//   address_i    - word address; only addresses below DEPTH are implemented
//   we_i         - write enable, active-high
//   data_i       - write data
//   test_start_i - preload request; overrides we_i and holds data_o
//   data_o       - registered read data
module ram_8bits
  import ram_8bits_pkg::*;
#(
  parameter int unsigned WIDTH  = ram_8bits_pkg::WIDTH,
  parameter int unsigned DEPTH  = ram_8bits_pkg::DEPTH,
  parameter int unsigned ADDR_W = ram_8bits_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              we_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              test_start_i,
  output logic [WIDTH-1:0]  data_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;

  // Range check against the implemented depth; upper address bits matter here.
  assign in_range_c = (address_i < ADDR_W'(DEPTH));
  assign idx_c      = address_i[IDX_W-1:0];

  // Next-state: preload > write (read-first) > plain read.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (test_start_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_d[i] = WIDTH'(test_image(5'(i)));
      end
    end else begin
      rdata_d = in_range_c ? mem_q[idx_c] : '0;
      if (we_i && in_range_c) begin
        mem_d[idx_c] = data_i;
      end
    end
  end

  // Array and output register share one async-reset process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_o = rdata_q;

endmodule

// File: tb/tb_ram_8bits.sv
// Directed self-checking bench for ram_8bits.
module tb_ram_8bits;

  logic       clk;
  logic       rst_n;
  logic [7:0] address_i;
  logic       we_i;
  logic [7:0] data_i;
  logic       test_start_i;
  logic [7:0] data_o;

  int checks;
  int errors;

  ram_8bits dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address_i    (address_i),
    .we_i         (we_i),
    .data_i       (data_i),
    .test_start_i (test_start_i),
    .data_o       (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, let one rising edge pass, sample 1ns later.
  task automatic step(input logic [7:0] a, input logic we, input logic [7:0] d,
                      input logic ts);
    @(negedge clk);
    address_i    = a;
    we_i         = we;
    data_i       = d;
    test_start_i = ts;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    address_i = '0; we_i = 1'b0; data_i = '0; test_start_i = 1'b0;
    #12;
    checks++;
    if (data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h expected 00", data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step(8'(i), 1'b0, 8'h00, 1'b0);
      checks++;
      if (data_o !== 8'h00) begin
        errors++;
        $display("FAIL reset_word%0d: got %h expected 00", i, data_o);
      end
    end
  endtask

  task automatic test_preload();
    logic [7:0] exp;
    step(8'd0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (data_o !== 8'h00) begin
      errors++;
      $display("FAIL preload_hold: got %h expected 00", data_o);
    end
    for (int i = 0; i < 20; i++) begin
      step(8'(i), 1'b0, 8'h00, 1'b0);
      exp = {5'(i), 3'b101};
      checks++;
      if (data_o !== exp) begin
        errors++;
        $display("FAIL preload_word%0d: got %h expected %h", i, data_o, exp);
      end
    end
    step(8'd31, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'hFD) begin
      errors++;
      $display("FAIL preload_word31: got %h expected fd", data_o);
    end
  endtask

  task automatic test_write_read();
    step(8'd7, 1'b1, 8'h5A, 1'b0);
    checks++;
    if (data_o !== 8'h3D) begin
      errors++;
      $display("FAIL write_read_first: got %h expected 3d", data_o);
    end
    step(8'd7, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h5A) begin
      errors++;
      $display("FAIL write_readback: got %h expected 5a", data_o);
    end
  endtask

  task automatic test_out_of_range();
    step(8'd40, 1'b1, 8'hFF, 1'b0);
    step(8'd40, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h00) begin
      errors++;
      $display("FAIL oor_read40: got %h expected 00", data_o);
    end
    step(8'd8, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h45) begin
      errors++;
      $display("FAIL oor_alias8: got %h expected 45", data_o);
    end
    step(8'd200, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h00) begin
      errors++;
      $display("FAIL oor_read200: got %h expected 00", data_o);
    end
  endtask

  task automatic test_priority();
    step(8'd7, 1'b0, 8'h00, 1'b0);
    step(8'd3, 1'b1, 8'h00, 1'b1);
    checks++;
    if (data_o !== 8'h5A) begin
      errors++;
      $display("FAIL prio_hold: got %h expected 5a", data_o);
    end
    step(8'd3, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h1D) begin
      errors++;
      $display("FAIL prio_word3: got %h expected 1d", data_o);
    end
    step(8'd7, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h3D) begin
      errors++;
      $display("FAIL prio_reload7: got %h expected 3d", data_o);
    end
  endtask

  task automatic test_back_to_back();
    // Held preload keeps blocking writes; then consecutive write/read pairs.
    step(8'd4, 1'b1, 8'hC3, 1'b1);
    step(8'd4, 1'b1, 8'hC3, 1'b1);
    checks++;
    if (data_o !== 8'h3D) begin
      errors++;
      $display("FAIL held_preload_hold: got %h expected 3d", data_o);
    end
    step(8'd4, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h25) begin
      errors++;
      $display("FAIL held_preload_word4: got %h expected 25", data_o);
    end
    step(8'd31, 1'b1, 8'h11, 1'b0);
    step(8'd0, 1'b1, 8'h22, 1'b0);
    checks++;
    if (data_o !== 8'h05) begin
      errors++;
      $display("FAIL b2b_old0: got %h expected 05", data_o);
    end
    step(8'd31, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h11) begin
      errors++;
      $display("FAIL b2b_read31: got %h expected 11", data_o);
    end
    step(8'd0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h22) begin
      errors++;
      $display("FAIL b2b_read0: got %h expected 22", data_o);
    end
  endtask

  task automatic test_reset_mid_op();
    step(8'd0, 1'b0, 8'h00, 1'b1);
    step(8'd2, 1'b1, 8'hAA, 1'b0);
    step(8'd5, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_o !== 8'h2D) begin
      errors++;
      $display("FAIL midop_pre: got %h expected 2d", data_o);
    end
    // Assert reset between edges: output must clear without a clock edge.
    @(negedge clk);
    test_start_i = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_o !== 8'h00) begin
      errors++;
      $display("FAIL midop_async_clear: got %h expected 00", data_o);
    end
    @(negedge clk);
    test_start_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step(8'(i), 1'b0, 8'h00, 1'b0);
      checks++;
      if (data_o !== 8'h00) begin
        errors++;
        $display("FAIL midop_word%0d: got %h expected 00", i, data_o);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_preload();
    test_write_read();
    test_out_of_range();
    test_priority();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
